// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 sign-magnitude max-pool with a half-width line buffer
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = IMG_W / 2;
  localparam int LW = HW > 1 ? $clog2(HW) : 1;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] h_q, h_d, out_data_q, out_data_d, p, q;
  logic [DW-1:0] lb_q [HW];
  logic [LW-1:0] idx;
  logic out_valid_q, out_valid_d, last_q, last_d, hs, load, lb_we, col_last, row_last;
  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic a_wins;
    a_wins = (a[DW-1] != b[DW-1]) ? b[DW-1] :
             a[DW-1] ? (a[DW-2:0] < b[DW-2:0]) : (a[DW-2:0] > b[DW-2:0]);
    return a_wins ? a : b;
  endfunction
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    hs          = in_valid && in_ready;
    col_last    = col_q == CW'(IMG_W - 1);
    row_last    = row_q == RW'(IMG_H - 1);
    idx         = LW'(col_q >> 1);
    p           = smax(h_q, in_data);
    q           = smax(lb_q[idx], p);
    load        = hs && col_q[0] && row_q[0];
    lb_we       = hs && col_q[0] && !row_q[0];
    col_d       = hs ? (col_last ? '0 : col_q + 1'b1) : col_q;
    row_d       = (hs && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
    h_d         = (hs && !col_q[0]) ? in_data : h_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d  = load ? q : out_data_q;
    last_d      = load ? (col_last && row_last) : last_q;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    frame_done  = out_valid_q && out_ready && last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      h_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
    end
  end
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[idx] <= p;
  end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: scoreboard bench for a 4x4 and a 28x28 instance sharing one stimulus bus
module tb_maxpool2x2_stream;
  typedef struct packed {logic last; logic [15:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst_n, sel, in_valid, out_ready;
  logic [15:0] in_data;
  logic s_in_ready, s_out_valid, s_frame_done, b_in_ready, b_out_valid, b_frame_done;
  logic [15:0] s_out_data, b_out_data;
  logic in_ready, out_valid, frame_done;
  logic [15:0] out_data;
  logic rst_n_s, rst_n_b;
  ent_t exp_q[$], rx_q[$];
  int checks = 0, errors = 0, stray = 0;
  always #5 clk = ~clk;
  assign rst_n_s    = rst_n && !sel;
  assign rst_n_b    = rst_n && sel;
  assign in_ready   = sel ? b_in_ready : s_in_ready;
  assign out_valid  = sel ? b_out_valid : s_out_valid;
  assign out_data   = sel ? b_out_data : s_out_data;
  assign frame_done = sel ? b_frame_done : s_frame_done;
  maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n_s), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .frame_done(s_frame_done));
  maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_W(28), .IMG_H(28)) dut_big (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .frame_done(b_frame_done));
  always @(negedge clk) begin
    if (out_valid && out_ready) rx_q.push_back({frame_done, out_data});
    else if (frame_done) stray++;
  end
  function automatic int key(input logic [15:0] v);
    return v[15] ? -2 * int'(v[14:0]) : 2 * int'(v[14:0]) + 1;
  endfunction
  function automatic logic [15:0] rmax(input logic [15:0] a, input logic [15:0] b);
    return key(a) >= key(b) ? a : b;
  endfunction
  task automatic push_model(input logic [15:0] px[$], input int w, input int h);
    for (int r = 0; r < h; r += 2)
      for (int c = 0; c < w; c += 2)
        exp_q.push_back({r == h - 2 && c == w - 2,
          rmax(rmax(px[r*w+c], px[r*w+c+1]), rmax(px[(r+1)*w+c], px[(r+1)*w+c+1]))});
  endtask
  task automatic drive_pix(input logic [15:0] d, input bit rnd);
    int t = 0;
    bit acc;
    if (rnd) while ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = d;
    forever begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      #1 acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (++t > 1000) begin
        checks++; errors++;
        $display("FAIL input_timeout got stalled %0d cycles want accept", t);
        break;
      end
    end
  endtask
  task automatic wait_out(input bit rnd);
    int t = 0;
    in_valid = 1'b0;
    while (rx_q.size() < exp_q.size() && t < 5000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic_sign;
    logic [15:0] f1[$] = '{16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd0, 16'd7, 16'd6,
      16'h8005, 16'h8002, 16'h8005, 16'h8002, 16'h8009, 16'h0000, 16'h8009, 16'h8001};
    logic [15:0] f2[$] = '{16'h8000, 16'h0000, 16'h0001, 16'h8001, 16'h8000, 16'h8000, 16'h7fff, 16'h8000,
      16'h8003, 16'h8007, 16'h0000, 16'h8000, 16'h8003, 16'h8004, 16'h0000, 16'h8000};
    ent_t r, e;
    exp_q.push_back({1'b0, 16'd5});
    exp_q.push_back({1'b0, 16'd7});
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b1, 16'h8001});
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h7fff});
    exp_q.push_back({1'b0, 16'h8003});
    exp_q.push_back({1'b1, 16'h0000});
    foreach (f1[i]) begin
      drive_pix(f1[i], 1'b0);
      if (i == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd5) begin
          errors++; $display("FAIL latency got v=%b d=%h want v=1 d=0005", out_valid, out_data);
        end
      end
    end
    foreach (f2[i]) drive_pix(f2[i], 1'b0);
    wait_out(1'b0);
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL basic_out got %h last=%b want %h last=%b", r.d, r.last, e.d, e.last); end
    end
    exp_q.delete(); rx_q.delete();
  endtask
  task automatic test_backpressure;
    logic [15:0] f[$];
    logic [15:0] held;
    bit rdy_bad = 0, data_bad = 0;
    ent_t r, e;
    for (int i = 0; i < 16; i++) f.push_back(16'(i * 37 + 3));
    push_model(f, 4, 4);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_pix(f[i], 1'b0);
    held = exp_q[0].d;
    in_valid = 1'b1; in_data = f[6];
    repeat (5) begin
      if (in_ready !== 1'b0) rdy_bad = 1;
      if (out_data !== held || out_valid !== 1'b1) data_bad = 1;
      @(posedge clk); #1;
    end
    checks++; if (rdy_bad) begin errors++; $display("FAIL bp_in_ready got 1 want 0 while stalled"); end
    checks++; if (data_bad) begin errors++; $display("FAIL bp_hold got %h want %h", out_data, held); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL bp_early got %0d outputs want 0", rx_q.size()); end
    out_ready = 1'b1;
    for (int i = 6; i < 16; i++) drive_pix(f[i], 1'b0);
    wait_out(1'b0);
    checks++;
    if (rx_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL bp_out got %h last=%b want %h last=%b", r.d, r.last, e.d, e.last); end
    end
    exp_q.delete(); rx_q.delete();
  endtask
  task automatic test_random_frame;
    logic [15:0] f[$];
    int fd = 0;
    ent_t r, e;
    sel = 1'b1;
    @(posedge clk); #1;
    stray = 0;
    for (int i = 0; i < 784; i++) f.push_back(16'($urandom));
    push_model(f, 28, 28);
    foreach (f[i]) drive_pix(f[i], 1'b1);
    wait_out(1'b1);
    checks++;
    if (rx_q.size() != 196) begin errors++; $display("FAIL rand_count got %0d want 196", rx_q.size()); end
    foreach (rx_q[i]) fd += int'(rx_q[i].last);
    checks++;
    if (fd != 1 || stray != 0) begin errors++; $display("FAIL rand_frame_done got %0d+%0d stray want 1", fd, stray); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL rand_out got %h last=%b want %h last=%b", r.d, r.last, e.d, e.last); end
    end
    exp_q.delete(); rx_q.delete();
    sel = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back;
    logic [15:0] f[$];
    int fd = 0;
    ent_t r, e;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) f.push_back(16'($urandom));
    push_model(f[0:15], 4, 4);
    push_model(f[16:31], 4, 4);
    foreach (f[i]) drive_pix(f[i], 1'b0);
    wait_out(1'b0);
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", rx_q.size()); end
    foreach (rx_q[i]) fd += int'(rx_q[i].last);
    checks++;
    if (fd != 2) begin errors++; $display("FAIL b2b_frame_done got %0d want 2", fd); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL b2b_out got %h last=%b want %h last=%b", r.d, r.last, e.d, e.last); end
    end
    exp_q.delete(); rx_q.delete();
  endtask
  task automatic test_reset_mid;
    logic [15:0] f[$];
    ent_t r, e;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive_pix(16'($urandom), 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b d=%h r=%b want v=0 d=0000 r=1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL mid_stale got %0d outputs want 0", rx_q.size()); end
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) f.push_back(16'($urandom));
    push_model(f, 4, 4);
    foreach (f[i]) drive_pix(f[i], 1'b0);
    wait_out(1'b0);
    checks++;
    if (rx_q.size() != 4) begin errors++; $display("FAIL mid_count got %0d want 4", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL mid_out got %h last=%b want %h last=%b", r.d, r.last, e.d, e.last); end
    end
    exp_q.delete(); rx_q.delete();
  endtask
  initial begin
    test_reset;
    test_basic_sign;
    test_backpressure;
    test_random_frame;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
